// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/step/drain sequencer for the 5-stage MIPS pipeline
module pipeline_run_ctrl #(
  parameter int          PC_WIDTH     = 7,
  parameter int          CNT_WIDTH    = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [5:0]  HALT_OPCODE  = 6'h3F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  input  logic                 halt_req,
  input  logic                 stop,
  input  logic [31:0]          instr_if,
  input  logic [PC_WIDTH-1:0]  pc_if,
  output logic                 fetch_en,
  output logic                 pipe_en,
  output logic                 flush_if,
  output logic                 busy,
  output logic                 done,
  output logic [PC_WIDTH-1:0]  halted_pc,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [PC_WIDTH-1:0]   halted_pc_q, halted_pc_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic cmd_accept;
  logic clear_cmd;
  logic halt_hit;

  // Only the opcode field of the fetched word matters here.
  logic unused_instr;
  assign unused_instr = ^instr_if[25:0];

  assign cmd_accept = cmd_valid & cmd_ready;
  assign clear_cmd  = cmd_accept & (cmd_op == OP_CLEAR);
  // A HALT sitting behind a load-use stall is not taken until fetch really advances.
  assign halt_hit   = fetch_en & ~stop & (instr_if[31:26] == HALT_OPCODE);

  // State, drain counter, halt PC and counters; reset aborts with no drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      halted_pc_q <= '0;
      cycle_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      halted_pc_q <= halted_pc_d;
      cycle_q     <= cycle_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state logic, including drain entry and halt PC capture.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halted_pc_d = halted_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          if (cmd_op == OP_RUN)        state_d = S_RUN;
          else if (cmd_op == OP_STEP)  state_d = S_STEP;
          else if (cmd_op == OP_CLEAR) halted_pc_d = '0;
        end
      end
      S_RUN: begin
        // halt_hit and halt_req both capture pc_if, so precedence does not change the PC.
        if (halt_hit || halt_req) begin
          halted_pc_d = pc_if;
          drain_d     = DRAIN_LOAD;
          state_d     = S_DRAIN;
        end
      end
      S_STEP: begin
        if (!stop) begin
          if (halt_hit) begin
            halted_pc_d = pc_if;
            drain_d     = DRAIN_LOAD;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      S_DONE: begin
        if (clear_cmd) begin
          halted_pc_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating cycle and stall counters; a clear overrides any increment.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (clear_cmd) begin
      cycle_d = '0;
      stall_d = '0;
    end else if (pipe_en) begin
      if (!(&cycle_q))         cycle_d = cycle_q + CNT_WIDTH'(1);
      if (stop && !(&stall_q)) stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    cmd_ready = 1'b0;
    fetch_en  = 1'b0;
    pipe_en   = 1'b0;
    flush_if  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_RUN:   begin fetch_en = 1'b1; pipe_en = 1'b1; busy = 1'b1; end
      S_STEP:  begin fetch_en = 1'b1; pipe_en = 1'b1; busy = 1'b1; end
      S_DRAIN: begin pipe_en = 1'b1; flush_if = 1'b1; busy = 1'b1; end
      S_DONE:  begin cmd_ready = 1'b1; done = 1'b1; end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign halted_pc   = halted_pc_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;

endmodule
